// File: rtl/alu_mdu_seq_pkg.sv
// Shared types for the execute unit: opcode encoding, FSM states and
// opcode classification helpers.
package alu_mdu_seq_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_PASS_A = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Raw 5-bit opcodes are used so that undefined encodings stay legal values.
  function automatic logic is_mul_op(logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Issue/writeback handshake bundle of the execute unit.
interface alu_mdu_seq_if import alu_mdu_seq_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) ();
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_res;
  logic            busy;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, busy
  );
endinterface

// File: rtl/alu_mdu_seq_mdu_iter.sv
// Iterative multiply/divide core: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one step per cycle, XLEN steps. The sign
// fixup is applied combinationally on the last step so the result is ready
// the same edge the counter expires.
module alu_mdu_seq_mdu_iter import alu_mdu_seq_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_FIRST = CW'(XLEN - 1);

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      op_q;
  logic            neg_q;
  logic            dz_q;
  logic [XLEN:0]   acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opd_q;

  logic            a_sgn, b_sgn, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   sum, rsh, diff, acc_n;
  logic [XLEN-1:0] lo_n;
  logic [2*XLEN-1:0] prod, prod_f;

  // Operand signs and magnitudes captured on entry
  always_comb begin
    a_sgn  = a[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
    b_sgn  = b[XLEN-1] && ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
    a_mag  = a_sgn ? -a : a;
    b_mag  = b_sgn ? -b : b;
    // Remainder follows the dividend; product and quotient follow both signs.
    neg_in = (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
  end

  // Iteration control: counter runs XLEN-1 down to 0, flush discards it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      run_q <= 1'b0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CNT_FIRST;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  // Datapath registers: loaded on start, stepped while running
  always_ff @(posedge clk) begin
    if (start) begin
      op_q  <= op;
      neg_q <= neg_in;
      dz_q  <= (b == '0);
      acc_q <= '0;
      lo_q  <= a_mag;
      opd_q <= b_mag;
    end else if (run_q) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
    end
  end

  // One multiply or restoring-divide step
  always_comb begin
    sum  = acc_q + (lo_q[0] ? {1'b0, opd_q} : '0);
    rsh  = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    diff = rsh - {1'b0, opd_q};
    if (is_div_op(op_q)) begin
      if (diff[XLEN]) begin
        acc_n = {1'b0, rsh[XLEN-1:0]};
        lo_n  = {lo_q[XLEN-2:0], 1'b0};
      end else begin
        acc_n = {1'b0, diff[XLEN-1:0]};
        lo_n  = {lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_n = {1'b0, sum[XLEN:1]};
      lo_n  = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Final sign fixup and RISC-V divide-by-zero override
  always_comb begin
    prod   = {acc_n[XLEN-1:0], lo_n};
    prod_f = neg_q ? -prod : prod;
    done   = run_q && (cnt_q == '0);
    case (op_q)
      OP_MUL:                     result = prod_f[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_f[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            result = dz_q ? '1 : (neg_q ? -lo_n : lo_n);
      OP_REM, OP_REMU:            result = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
      default:                    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// RV32I/RV64I execute unit with M extension. Single-cycle ALU ops, iterative
// MUL*/DIV*/REM*, valid/ready on issue and writeback sides, one result register.
module alu_mdu_seq import alu_mdu_seq_pkg::*; #(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter bit MUL_ITER = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  alu_mdu_seq_if.slave bus
);
  localparam int SW = $clog2(XLEN);

  state_e                 state_q, state_d;
  logic [4:0]             op;
  logic                   iter_op, accept, start_iter, iter_done;
  logic                   in_ready, out_valid, busy;
  logic [XLEN-1:0]        alu_res, iter_res, res_q;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [SW-1:0]          shamt;
  logic                   a_sx, b_sx;
  logic [2*XLEN-1:0]      a_ext, b_ext, prod;

  assign op         = bus.in_op;
  assign iter_op    = is_div_op(op) || (MUL_ITER && is_mul_op(op));
  assign accept     = bus.in_valid && in_ready && !bus.flush;
  assign start_iter = accept && iter_op;

  alu_mdu_seq_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_iter),
    .flush  (bus.flush),
    .op     (op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .done   (iter_done),
    .result (iter_res)
  );

  // Single-cycle result mux; undefined opcodes fall through to ADD
  always_comb begin
    a_s   = bus.in_a;
    b_s   = bus.in_b;
    shamt = bus.in_b[SW-1:0];
    a_sx  = ((op == OP_MULH) || (op == OP_MULHSU)) && bus.in_a[XLEN-1];
    b_sx  = (op == OP_MULH) && bus.in_b[XLEN-1];
    a_ext = {{XLEN{a_sx}}, bus.in_a};
    b_ext = {{XLEN{b_sx}}, bus.in_b};
    if (MUL_ITER) prod = '0;
    else          prod = a_ext * b_ext;
    case (op)
      OP_SUB:                       alu_res = bus.in_a - bus.in_b;
      OP_AND:                       alu_res = bus.in_a & bus.in_b;
      OP_OR:                        alu_res = bus.in_a | bus.in_b;
      OP_XOR:                       alu_res = bus.in_a ^ bus.in_b;
      OP_SLL:                       alu_res = bus.in_a << shamt;
      OP_SRL:                       alu_res = bus.in_a >> shamt;
      OP_SRA:                       alu_res = a_s >>> shamt;
      OP_SLT:                       alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:                      alu_res = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
      OP_PASS_A:                    alu_res = bus.in_a;
      OP_MUL:                       alu_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: alu_res = prod[2*XLEN-1:XLEN];
      default:                      alu_res = bus.in_a + bus.in_b;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: flush wins, DONE may re-issue in the cycle it drains
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept)                                  state_d = iter_op ? BUSY : DONE;
          else if ((state_q == DONE) && bus.out_ready) state_d = IDLE;
        end
        BUSY:    if (iter_done) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    out_valid = (state_q == DONE);
    busy      = (state_q == BUSY);
  end

  // Result register: written only on a new result, so a stalled result holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                res_q <= '0;
    else if (accept && !iter_op)                               res_q <= alu_res;
    else if ((state_q == BUSY) && iter_done && !bus.flush)     res_q <= iter_res;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_res   = res_q;

endmodule
